uc_implied_collector: RTL and testbench
=======================================

Name: uc_implied_collector

Overview:
- Upstream neighbour of the unit-clause arbiter; buffers implied unit-clause literals produced by each BCP engine in one small FIFO per engine.
- Presents them to the arbiter in one of two modes:
  - Mask mode: the arbiter's one-hot engmask selects the engine FIFO, and the arbiter takes the head explicitly.
  - PQ mode: the collector round-robins over non-empty FIFOs and issues one registered literal per cycle.
- Drives eng2uca, eng2uca_valid, eng2uca_empty and per-engine eng2uca_full.

Parameters:
- NUM_ENGINE, 4, number of BCP engines / FIFOs.
- LIT_IDX_MAX, 32, maximum literal index; LIT_W = $clog2(LIT_IDX_MAX)+1 (signed literal width, 6 by default).
- DEPTH, 4, entries per engine FIFO (power of two, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- eng_push  in  NUM_ENGINE  per-engine push strobe for an implied literal.
- eng_lit  in  NUM_ENGINE x LIT_W  per-engine signed implied literal.
- flush  in  1  synchronous clear of all FIFOs and PQ output.
- input_mode  in  1  0 = mask mode, 1 = PQ mode (same encoding as the arbiter).
- engmask  in  NUM_ENGINE  engine select from the arbiter (mask mode only).
- uca_take  in  1  arbiter consumed the presented head this cycle (mask mode only).
- eng2uca  out  LIT_W  signed literal to the arbiter.
- eng2uca_valid  out  1  PQ-mode literal valid (one-cycle pulse per literal).
- eng2uca_empty  out  1  no literal available in the current mode.
- eng2uca_full  out  NUM_ENGINE  per-engine FIFO full.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async, rst=1):
  - All FIFO pointers and counts = 0.
  - eng2uca = 0, eng2uca_valid = 0, eng2uca_empty = 1, eng2uca_full = 0, overflow = 0.
  - Round-robin pointer rr = 0; state = MASK.
  - Reset mid-operation discards all buffered literals.
- FIFO (per engine):
  - Circular buffer with count 0..DEPTH; eng2uca_full[i] = (count == DEPTH), combinational from registers.
  - Push with eng_lit == 0 is ignored; 0 is not a legal literal and does not set overflow.
  - Push when full with no pop in the same cycle: literal dropped, overflow set until reset or flush.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Pop when empty: ignored. Push and pop on an empty FIFO: push lands, count = 1.
  - Wrap-around of read/write pointers is modulo DEPTH.
- State machine (registered):
  - MASK to PQ when input_mode = 1.
  - PQ to MASK when input_mode = 0; eng2uca_valid is forced to 0 on that cycle.
  - flush in either state: all counts = 0, eng2uca_valid = 0, overflow = 0, rr = 0, state unchanged.
  - flush has priority over a same-cycle push or pop.
- MASK state (combinational read path, zero latency):
  - sel = lowest set bit of engmask; if engmask == 0 there is no selection.
  - eng2uca = head of FIFO[sel], else 0.
  - eng2uca_empty = 1 if no selection or FIFO[sel] is empty.
  - Pop FIFO[sel] when uca_take = 1 and eng2uca_empty = 0.
  - eng2uca_valid = 0.
- PQ state (registered output, 1-cycle latency):
  - Each cycle, grant the first non-empty FIFO searching from rr upward, with wrap.
  - Pop the granted FIFO.
  - Next cycle: eng2uca = popped literal, eng2uca_valid = 1.
  - rr <= grant+1 mod NUM_ENGINE.
  - No grant: eng2uca_valid <= 0, eng2uca holds its last value.
  - The arbiter always accepts in PQ mode; there is no backpressure.
  - eng2uca_empty = 1 when all FIFOs are empty and eng2uca_valid = 0.
- A same-cycle push to the FIFO being popped is legal in both modes. Order per engine is strictly FIFO.

Test Plan:
- Reset: assert rst mid-stream with 3 literals in FIFO[1] -> all full = 0, eng2uca_empty = 1, overflow = 0; after release, engmask = 0010 shows empty.
- Mask mode: push +5 then -7 into engine 2, engmask = 0100, uca_take pulsed twice -> eng2uca = 5 then -7; then eng2uca_empty = 1. engmask = 0 -> eng2uca_empty = 1, eng2uca = 0.
- Full/overflow (DEPTH = 4): push 5 literals to engine 0 with no pops -> full[0] = 1 after the 4th, 5th dropped, overflow = 1. Next cycle push plus take -> count stays 4, overflow unchanged.
- PQ round-robin: engine 0 holds +1 and +2, engine 3 holds -4, input_mode = 1 -> valid pulses over 3 cycles carry 1, -4, 2 (rr rotates); then valid = 0, eng2uca_empty = 1.
- Zero literal plus flush: push literal 0 -> count unchanged. Push +9 to engine 1, then flush -> full = 0, eng2uca_empty = 1, overflow cleared.
- Mode switch: PQ with valid = 1, input_mode drops to 0 -> valid = 0 the next cycle, and the remaining literals are readable via engmask in order.

Source files
------------

// File: rtl/uc_implied_collector.sv
// Per-engine implied-literal FIFOs feeding the unit-clause arbiter, either
// selected by the arbiter's engine mask or drained round-robin in PQ mode.
module uc_implied_collector #(
  parameter int NUM_ENGINE  = 4,
  parameter int LIT_IDX_MAX = 32,
  parameter int DEPTH       = 4,
  parameter int LIT_W       = $clog2(LIT_IDX_MAX) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_ENGINE-1:0]           eng_push,
  input  logic [NUM_ENGINE-1:0][LIT_W-1:0] eng_lit,
  input  logic                            flush,
  input  logic                            input_mode,
  input  logic [NUM_ENGINE-1:0]           engmask,
  input  logic                            uca_take,
  output logic [LIT_W-1:0]                eng2uca,
  output logic                            eng2uca_valid,
  output logic                            eng2uca_empty,
  output logic [NUM_ENGINE-1:0]           eng2uca_full,
  output logic                            overflow,
  output logic                            dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    ST_MASK = 1'b0,
    ST_PQ   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LIT_W-1:0] r_mem   [NUM_ENGINE][DEPTH];
  logic [PW-1:0]    r_wptr  [NUM_ENGINE];
  logic [PW-1:0]    r_rptr  [NUM_ENGINE];
  logic [CW-1:0]    r_count [NUM_ENGINE];
  logic [RW-1:0]    r_rr;
  logic [LIT_W-1:0] r_pq_lit;
  logic             r_pq_valid;
  logic             r_overflow;

  logic [NUM_ENGINE-1:0] w_nonempty;
  logic [NUM_ENGINE-1:0] w_full;
  logic [NUM_ENGINE-1:0] w_push_req;
  logic [NUM_ENGINE-1:0] w_push_ok;
  logic [NUM_ENGINE-1:0] w_pop;
  logic [LIT_W-1:0]      w_head [NUM_ENGINE];
  logic                  w_overflow_evt;

  logic [RW-1:0]    w_sel;
  logic             w_sel_hit;
  logic [RW-1:0]    w_grant;
  logic             w_grant_hit;
  logic [RW-1:0]    w_rr_next;
  logic             w_pq_load;
  logic             w_mask_empty;
  logic [LIT_W-1:0] w_mask_lit;

  // A zero literal is not a legal push; a full FIFO only accepts when it pops.
  always_comb begin
    w_overflow_evt = 1'b0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      w_full[i]     = (r_count[i] == FULL_CNT);
      w_head[i]     = r_mem[i][r_rptr[i]];
      w_push_req[i] = eng_push[i] && (eng_lit[i] != '0);
      w_push_ok[i]  = w_push_req[i] && (!w_full[i] || w_pop[i]);
      if (w_push_req[i] && w_full[i] && !w_pop[i]) begin
        w_overflow_evt = 1'b1;
      end
    end
  end

  // Lowest set bit of engmask wins.
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel     = '0;
    for (int i = NUM_ENGINE - 1; i >= 0; i--) begin
      if (engmask[i]) begin
        w_sel_hit = 1'b1;
        w_sel     = RW'(i);
      end
    end
  end

  // Round-robin search starting at r_rr; descending scan leaves the nearest hit.
  always_comb begin
    w_grant_hit = 1'b0;
    w_grant     = '0;
    for (int k = NUM_ENGINE - 1; k >= 0; k--) begin
      if (w_nonempty[(int'(r_rr) + k) % NUM_ENGINE]) begin
        w_grant_hit = 1'b1;
        w_grant     = RW'((int'(r_rr) + k) % NUM_ENGINE);
      end
    end
    w_rr_next = (w_grant == RW'(NUM_ENGINE - 1)) ? '0 : w_grant + 1'b1;
  end

  always_comb begin
    w_state_next  = r_state;
    w_pop         = '0;
    w_pq_load     = 1'b0;
    w_mask_empty  = !(w_sel_hit && w_nonempty[w_sel]);
    w_mask_lit    = w_mask_empty ? '0 : w_head[w_sel];
    eng2uca       = w_mask_lit;
    eng2uca_empty = w_mask_empty;
    case (r_state)
      ST_MASK: begin
        if (input_mode) w_state_next = ST_PQ;
        if (uca_take && !w_mask_empty) w_pop[w_sel] = 1'b1;
      end
      ST_PQ: begin
        eng2uca       = r_pq_lit;
        eng2uca_empty = !(|w_nonempty) && !r_pq_valid;
        // Leaving PQ pops nothing so no literal is lost on the way out.
        if (!input_mode) begin
          w_state_next = ST_MASK;
        end else if (w_grant_hit) begin
          w_pop[w_grant] = 1'b1;
          w_pq_load      = 1'b1;
        end
      end
      default: w_state_next = ST_MASK;
    endcase
    if (flush) begin
      w_state_next = r_state;
      w_pop        = '0;
      w_pq_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_MASK;
      r_rr       <= '0;
      r_pq_lit   <= '0;
      r_pq_valid <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_rr       <= '0;
        r_pq_lit   <= '0;
        r_pq_valid <= 1'b0;
        r_overflow <= 1'b0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
          r_wptr[i]  <= '0;
          r_rptr[i]  <= '0;
          r_count[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_ENGINE; i++) begin
          if (w_push_ok[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
          if (w_pop[i])     r_rptr[i] <= r_rptr[i] + 1'b1;
          r_count[i] <= r_count[i] + CW'(w_push_ok[i]) - CW'(w_pop[i]);
        end
        if (w_overflow_evt) r_overflow <= 1'b1;
        r_pq_valid <= w_pq_load;
        if (w_pq_load) begin
          r_pq_lit <= w_head[w_grant];
          r_rr     <= w_rr_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENGINE; i++) begin
      if (!flush && w_push_ok[i]) r_mem[i][r_wptr[i]] <= eng_lit[i];
    end
  end

  assign eng2uca_valid = r_pq_valid;
  assign eng2uca_full  = w_full;
  assign overflow      = r_overflow;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uc_implied_collector.sv
// Directed bench for uc_implied_collector: reset, mask reads, overflow,
// PQ round-robin, zero literal / flush and the PQ-to-mask switch.
module tb_uc_implied_collector;

  localparam int NE = 4;
  localparam int LW = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NE-1:0]         eng_push = '0;
  logic [NE-1:0][LW-1:0] eng_lit = '0;
  logic                  flush = 1'b0;
  logic                  input_mode = 1'b0;
  logic [NE-1:0]         engmask = '0;
  logic                  uca_take = 1'b0;
  logic [LW-1:0]         eng2uca;
  logic                  eng2uca_valid;
  logic                  eng2uca_empty;
  logic [NE-1:0]         eng2uca_full;
  logic                  overflow;
  logic                  dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  uc_implied_collector dut (
    .clk(clk), .rst(rst), .eng_push(eng_push), .eng_lit(eng_lit),
    .flush(flush), .input_mode(input_mode), .engmask(engmask),
    .uca_take(uca_take), .eng2uca(eng2uca), .eng2uca_valid(eng2uca_valid),
    .eng2uca_empty(eng2uca_empty), .eng2uca_full(eng2uca_full),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int eng, input int lit);
    eng_push[eng] = 1'b1;
    eng_lit[eng]  = LW'(lit);
    tick();
    eng_push = '0;
    eng_lit  = '0;
  endtask

  task automatic take_one();
    uca_take = 1'b1;
    tick();
    uca_take = 1'b0;
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    n_total++; if (eng2uca_empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", eng2uca_empty); else n_pass++;
    n_total++; if (eng2uca_full !== 4'b0000) $display("FAIL rst_full got %b exp 0000", eng2uca_full); else n_pass++;
    n_total++; if (eng2uca !== 6'd0) $display("FAIL rst_lit got %h exp 00", eng2uca); else n_pass++;
    n_total++; if (eng2uca_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_valid_ovf got %b%b exp 00", eng2uca_valid, overflow); else n_pass++;
    push_one(1, 3); push_one(1, 4); push_one(1, 6);
    engmask = 4'b0010;
    #1;
    n_total++; if (eng2uca !== 6'd3 || eng2uca_empty !== 1'b0) $display("FAIL pre_rst_head got %h/%b exp 03/0", eng2uca, eng2uca_empty); else n_pass++;
    rst = 1'b1;
    #2;
    n_total++; if (eng2uca_empty !== 1'b1 || eng2uca_full !== 4'b0 || overflow !== 1'b0) $display("FAIL mid_rst got e%b f%b o%b exp e1 f0000 o0", eng2uca_empty, eng2uca_full, overflow); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (eng2uca_empty !== 1'b1 || eng2uca !== 6'd0) $display("FAIL post_rst_e1 got %b/%h exp 1/00", eng2uca_empty, eng2uca); else n_pass++;
    engmask = '0;
  endtask

  task automatic test_mask_mode();
    push_one(2, 5); push_one(2, -7);
    engmask = 4'b0100;
    #1;
    n_total++; if (eng2uca !== 6'd5 || eng2uca_empty !== 1'b0) $display("FAIL mask_head1 got %h/%b exp 05/0", eng2uca, eng2uca_empty); else n_pass++;
    engmask = 4'b1110;
    #1;
    n_total++; if (eng2uca_empty !== 1'b1) $display("FAIL mask_lowest_sel got %b exp 1", eng2uca_empty); else n_pass++;
    engmask = 4'b0100;
    take_one();
    n_total++; if (eng2uca !== 6'(-7) || eng2uca_empty !== 1'b0) $display("FAIL mask_head2 got %h/%b exp 39/0", eng2uca, eng2uca_empty); else n_pass++;
    take_one();
    n_total++; if (eng2uca_empty !== 1'b1) $display("FAIL mask_drained got %b exp 1", eng2uca_empty); else n_pass++;
    engmask = '0;
    #1;
    n_total++; if (eng2uca_empty !== 1'b1 || eng2uca !== 6'd0) $display("FAIL mask_none got %b/%h exp 1/00", eng2uca_empty, eng2uca); else n_pass++;
    n_total++; if (eng2uca_valid !== 1'b0) $display("FAIL mask_valid got %b exp 0", eng2uca_valid); else n_pass++;
  endtask

  task automatic test_full_overflow();
    logic [LW-1:0] exp_q[$];
    push_one(0, 10); push_one(0, 11); push_one(0, 12);
    n_total++; if (eng2uca_full[0] !== 1'b0) $display("FAIL full_at3 got %b exp 0", eng2uca_full[0]); else n_pass++;
    push_one(0, 13);
    n_total++; if (eng2uca_full !== 4'b0001 || overflow !== 1'b0) $display("FAIL full_at4 got %b/%b exp 0001/0", eng2uca_full, overflow); else n_pass++;
    push_one(0, 14);
    n_total++; if (overflow !== 1'b1 || eng2uca_full[0] !== 1'b1) $display("FAIL ovf_set got %b/%b exp 1/1", overflow, eng2uca_full[0]); else n_pass++;
    engmask = 4'b0001;
    eng_push[0] = 1'b1;
    eng_lit[0]  = 6'd15;
    uca_take    = 1'b1;
    tick();
    eng_push = '0; eng_lit = '0; uca_take = 1'b0;
    #1;
    n_total++; if (eng2uca_full[0] !== 1'b1 || overflow !== 1'b1) $display("FAIL push_pop_full got %b/%b exp 1/1", eng2uca_full[0], overflow); else n_pass++;
    exp_q = '{6'd11, 6'd12, 6'd13, 6'd15};
    foreach (exp_q[k]) begin
      n_total++; if (eng2uca !== exp_q[k] || eng2uca_empty !== 1'b0) $display("FAIL drain_order[%0d] got %h exp %h", k, eng2uca, exp_q[k]); else n_pass++;
      take_one();
    end
    n_total++; if (eng2uca_empty !== 1'b1 || eng2uca_full[0] !== 1'b0) $display("FAIL drain_empty got %b/%b exp 1/0", eng2uca_empty, eng2uca_full[0]); else n_pass++;
    engmask = '0;
  endtask

  task automatic test_zero_flush();
    engmask = 4'b0010;
    push_one(1, 0);
    n_total++; if (eng2uca_empty !== 1'b1 || overflow !== 1'b1) $display("FAIL zero_lit got %b/%b exp 1/1", eng2uca_empty, overflow); else n_pass++;
    push_one(1, 9);
    n_total++; if (eng2uca !== 6'd9 || eng2uca_empty !== 1'b0) $display("FAIL push9 got %h/%b exp 09/0", eng2uca, eng2uca_empty); else n_pass++;
    for (int k = 0; k < 4; k++) push_one(3, 20 + k);
    n_total++; if (eng2uca_full !== 4'b1000) $display("FAIL full3 got %b exp 1000", eng2uca_full); else n_pass++;
    do_flush();
    n_total++; if (eng2uca_full !== 4'b0 || eng2uca_empty !== 1'b1 || overflow !== 1'b0) $display("FAIL flush got f%b e%b o%b exp f0000 e1 o0", eng2uca_full, eng2uca_empty, overflow); else n_pass++;
    engmask = '0;
  endtask

  task automatic test_pq_rr();
    logic [LW-1:0] exp_q[$];
    push_one(0, 1); push_one(0, 2); push_one(3, -4);
    input_mode = 1'b1;
    tick();
    n_total++; if (dbg_state !== 1'b1 || eng2uca_valid !== 1'b0 || eng2uca_empty !== 1'b0) $display("FAIL pq_enter got s%b v%b e%b exp s1 v0 e0", dbg_state, eng2uca_valid, eng2uca_empty); else n_pass++;
    exp_q = '{6'd1, 6'(-4), 6'd2};
    foreach (exp_q[k]) begin
      tick();
      n_total++; if (eng2uca_valid !== 1'b1 || eng2uca !== exp_q[k]) $display("FAIL pq_out[%0d] got v%b %h exp v1 %h", k, eng2uca_valid, eng2uca, exp_q[k]); else n_pass++;
    end
    tick();
    n_total++; if (eng2uca_valid !== 1'b0 || eng2uca_empty !== 1'b1 || eng2uca !== 6'd2) $display("FAIL pq_idle got v%b e%b %h exp v0 e1 02", eng2uca_valid, eng2uca_empty, eng2uca); else n_pass++;
  endtask

  task automatic test_mode_switch();
    input_mode = 1'b0;
    tick();
    n_total++; if (dbg_state !== 1'b0) $display("FAIL back_to_mask got %b exp 0", dbg_state); else n_pass++;
    push_one(2, 20); push_one(2, 21); push_one(2, 22);
    input_mode = 1'b1;
    tick();
    tick();
    n_total++; if (eng2uca_valid !== 1'b1 || eng2uca !== 6'd20) $display("FAIL sw_pq_out got v%b %h exp v1 14", eng2uca_valid, eng2uca); else n_pass++;
    input_mode = 1'b0;
    tick();
    n_total++; if (eng2uca_valid !== 1'b0 || dbg_state !== 1'b0) $display("FAIL sw_valid_drop got v%b s%b exp v0 s0", eng2uca_valid, dbg_state); else n_pass++;
    engmask = 4'b0100;
    #1;
    n_total++; if (eng2uca !== 6'd21 || eng2uca_empty !== 1'b0) $display("FAIL sw_head1 got %h/%b exp 15/0", eng2uca, eng2uca_empty); else n_pass++;
    take_one();
    n_total++; if (eng2uca !== 6'd22 || eng2uca_empty !== 1'b0) $display("FAIL sw_head2 got %h/%b exp 16/0", eng2uca, eng2uca_empty); else n_pass++;
    take_one();
    n_total++; if (eng2uca_empty !== 1'b1) $display("FAIL sw_drained got %b exp 1", eng2uca_empty); else n_pass++;
    engmask = '0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_mask_mode();
    test_full_overflow();
    test_zero_flush();
    test_pq_rr();
    test_mode_switch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
